// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the processor fetch port, processor data port and the single-port
// memory bus that mem_arbiter sits between, plus the two sticky status flags.
//   master modport: the arbiter view (drives op_*, samples ip_*).
//   slave modport : the environment view (processor + memory; drives ip_*, samples op_*).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // Instruction fetch port
  logic                  ip_inst_req;
  logic [ADDR_WIDTH-1:0] ip_inst_addr;
  logic                  op_inst_valid;
  logic [31:0]           op_inst_from_mem;
  // Data port
  logic                  ip_data_rd;
  logic                  ip_data_wr;
  logic [ADDR_WIDTH-1:0] ip_data_addr;
  logic [3:0]            ip_data_mask;
  logic [31:0]           ip_data_from_proc;
  logic                  op_data_valid;
  logic [31:0]           op_data_from_mem;
  // Memory port
  logic                  op_mem_req;
  logic [ADDR_WIDTH-1:0] op_mem_addr;
  logic                  op_mem_wr;
  logic [3:0]            op_mem_mask;
  logic [31:0]           op_mem_wdata;
  logic                  ip_mem_ack;
  logic [31:0]           ip_mem_rdata;
  // Status
  logic                  op_halted;
  logic                  op_bus_error;

  modport master (
    input  ip_inst_req, ip_inst_addr,
    output op_inst_valid, op_inst_from_mem,
    input  ip_data_rd, ip_data_wr, ip_data_addr, ip_data_mask, ip_data_from_proc,
    output op_data_valid, op_data_from_mem,
    output op_mem_req, op_mem_addr, op_mem_wr, op_mem_mask, op_mem_wdata,
    input  ip_mem_ack, ip_mem_rdata,
    output op_halted, op_bus_error
  );

  modport slave (
    output ip_inst_req, ip_inst_addr,
    input  op_inst_valid, op_inst_from_mem,
    output ip_data_rd, ip_data_wr, ip_data_addr, ip_data_mask, ip_data_from_proc,
    input  op_data_valid, op_data_from_mem,
    input  op_mem_req, op_mem_addr, op_mem_wr, op_mem_mask, op_mem_wdata,
    output ip_mem_ack, ip_mem_rdata,
    input  op_halted, op_bus_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch and data ports of
// the processor. Round-robin on contention, one transaction at a time, each bounded by a
// timeout. Once EBREAK_INST has been fetched, further fetches are answered locally with
// EBREAK_INST and never reach memory.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mem_arbiter_if.master (fetch port, data port, memory port, status flags)
// All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] EBREAK_INST    = 32'h0010_0073
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StInst, StData, StResp} state_e;

  state_e          state_q;
  logic            last_grant_q;  // 0: inst, 1: data
  logic [CntW-1:0] cnt_q;
  logic            resp_pend_q;   // halted fetch: valid still to be raised in RESP

  logic data_req;
  logic any_req;
  logic grant_data;

  always_comb begin
    data_req   = bus.ip_data_rd | bus.ip_data_wr;
    any_req    = data_req | bus.ip_inst_req;
    // Data wins when alone, or on contention when inst was granted last.
    grant_data = data_req & (~bus.ip_inst_req | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= StIdle;
      last_grant_q         <= 1'b0;
      cnt_q                <= '0;
      resp_pend_q          <= 1'b0;
      bus.op_inst_valid    <= 1'b0;
      bus.op_inst_from_mem <= 32'h0;
      bus.op_data_valid    <= 1'b0;
      bus.op_data_from_mem <= 32'h0;
      bus.op_mem_req       <= 1'b0;
      bus.op_mem_addr      <= {ADDR_WIDTH{1'b0}};
      bus.op_mem_wr        <= 1'b0;
      bus.op_mem_mask      <= 4'h0;
      bus.op_mem_wdata     <= 32'h0;
      bus.op_halted        <= 1'b0;
      bus.op_bus_error     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            last_grant_q <= grant_data;
            cnt_q        <= '0;
            if (grant_data) begin
              bus.op_mem_req   <= 1'b1;
              bus.op_mem_addr  <= bus.ip_data_addr;
              bus.op_mem_wr    <= bus.ip_data_wr;
              bus.op_mem_mask  <= bus.ip_data_wr ? bus.ip_data_mask : 4'hF;
              bus.op_mem_wdata <= bus.ip_data_wr ? bus.ip_data_from_proc : 32'h0;
              state_q          <= StData;
            end else if (bus.op_halted) begin
              // Answered locally; memory is never requested.
              resp_pend_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              bus.op_mem_req   <= 1'b1;
              bus.op_mem_addr  <= bus.ip_inst_addr;
              bus.op_mem_wr    <= 1'b0;
              bus.op_mem_mask  <= 4'hF;
              bus.op_mem_wdata <= 32'h0;
              state_q          <= StInst;
            end
          end
        end

        StInst: begin
          if (bus.ip_mem_ack) begin
            bus.op_mem_req       <= 1'b0;
            bus.op_inst_valid    <= 1'b1;
            bus.op_inst_from_mem <= bus.ip_mem_rdata;
            if (bus.ip_mem_rdata == EBREAK_INST) begin
              bus.op_halted <= 1'b1;
            end
            state_q <= StResp;
          end else if (cnt_q == LastCnt) begin
            bus.op_mem_req       <= 1'b0;
            bus.op_inst_valid    <= 1'b1;
            bus.op_inst_from_mem <= 32'h0;
            bus.op_bus_error     <= 1'b1;
            state_q              <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StData: begin
          if (bus.ip_mem_ack) begin
            bus.op_mem_req       <= 1'b0;
            bus.op_data_valid    <= 1'b1;
            bus.op_data_from_mem <= bus.op_mem_wr ? 32'h0 : bus.ip_mem_rdata;
            state_q              <= StResp;
          end else if (cnt_q == LastCnt) begin
            bus.op_mem_req       <= 1'b0;
            bus.op_data_valid    <= 1'b1;
            bus.op_data_from_mem <= 32'h0;
            bus.op_bus_error     <= 1'b1;
            state_q              <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StResp: begin
          if (resp_pend_q) begin
            // Extra RESP cycle keeps halted fetches on the normal 2-cycle latency.
            resp_pend_q          <= 1'b0;
            bus.op_inst_valid    <= 1'b1;
            bus.op_inst_from_mem <= EBREAK_INST;
          end else begin
            bus.op_inst_valid <= 1'b0;
            bus.op_data_valid <= 1'b0;
            state_q           <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned TO   = 16;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(TO),
    .EBREAK_INST   (EBRK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory contents seen by the responder, and the reference copy kept by the model.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  bit          m_halted;
  bit          m_err;

  // Memory responder state and per-request observations.
  int          ack_delay;  // wait cycles before ack; negative: never ack
  int          req_cnt;
  int          req_cycles;
  logic [31:0] f_addr;
  logic        f_wr;
  logic [3:0]  f_mask;
  logic [31:0] f_wdata;
  bit          f_unstable;
  logic [31:0] addr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.op_mem_req === 1'b1) begin
      if (req_cnt == 0) begin
        f_addr  = bus.op_mem_addr;
        f_wr    = bus.op_mem_wr;
        f_mask  = bus.op_mem_mask;
        f_wdata = bus.op_mem_wdata;
        addr_q.push_back(bus.op_mem_addr);
      end else if (f_addr !== bus.op_mem_addr || f_wr !== bus.op_mem_wr ||
                   f_mask !== bus.op_mem_mask || f_wdata !== bus.op_mem_wdata) begin
        f_unstable = 1'b1;
      end
      req_cycles++;
      if (ack_delay >= 0 && req_cnt == ack_delay) begin
        bus.ip_mem_ack = 1'b1;
        if (bus.op_mem_wr) begin
          bus.ip_mem_rdata = $urandom;
          for (int b = 0; b < 4; b++)
            if (bus.op_mem_mask[b]) mem[bus.op_mem_addr[7:2]][8*b +: 8] = bus.op_mem_wdata[8*b +: 8];
        end else begin
          bus.ip_mem_rdata = mem[bus.op_mem_addr[7:2]];
        end
      end else begin
        bus.ip_mem_ack   = 1'b0;
        bus.ip_mem_rdata = $urandom;
      end
      req_cnt++;
    end else begin
      // Stray acks while nothing is requested must be ignored.
      bus.ip_mem_ack   = ($urandom_range(0, 3) == 0);
      bus.ip_mem_rdata = $urandom;
      req_cnt          = 0;
    end
  end

  task automatic clear_reqs();
    bus.ip_inst_req  = 1'b0;
    bus.ip_data_rd   = 1'b0;
    bus.ip_data_wr   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.op_mem_req, bus.op_inst_valid, bus.op_data_valid,
                              bus.op_mem_wr, bus.op_mem_mask, bus.op_halted, bus.op_bus_error}),
          64'h0);
    check({tag, "_iword"}, 64'(bus.op_inst_from_mem), 64'h0);
    check({tag, "_dword"}, 64'(bus.op_data_from_mem), 64'h0);
    check({tag, "_maddr"}, 64'(bus.op_mem_addr), 64'h0);
    check({tag, "_mwdata"}, 64'(bus.op_mem_wdata), 64'h0);
  endtask

  // kind: 0 fetch, 1 load, 2 store. Called with the DUT idle, at a negedge.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input int delay, input string tag);
    logic [31:0] exp_word;
    logic [31:0] word;
    int          exp_lat;
    int          exp_req;
    int          k;
    bit          got;
    bit          wrong;
    bit          halted_fetch;
    halted_fetch = (kind == 0) && m_halted;
    word         = 32'h0;
    if (halted_fetch) begin
      exp_word = EBRK;
      exp_lat  = 2;
      exp_req  = 0;
    end else if (delay < 0) begin
      exp_word = 32'h0;
      exp_lat  = TO + 1;
      exp_req  = TO;
      m_err    = 1'b1;
    end else begin
      exp_lat  = delay + 2;
      exp_req  = delay + 1;
      exp_word = (kind == 2) ? 32'h0 : ref_mem[addr[7:2]];
      if (kind == 2)
        for (int b = 0; b < 4; b++) if (mask[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      if (kind == 0 && exp_word == EBRK) m_halted = 1'b1;
    end

    ack_delay  = delay;
    req_cycles = 0;
    f_unstable = 1'b0;
    bus.ip_inst_req       = (kind == 0);
    bus.ip_inst_addr      = addr;
    bus.ip_data_rd        = (kind == 1);
    bus.ip_data_wr        = (kind == 2);
    bus.ip_data_addr      = addr;
    bus.ip_data_mask      = mask;
    bus.ip_data_from_proc = wdata;

    k = 0; got = 1'b0; wrong = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (kind == 0) begin
        if (bus.op_inst_valid) begin got = 1'b1; word = bus.op_inst_from_mem; end
        if (bus.op_data_valid) wrong = 1'b1;
      end else begin
        if (bus.op_data_valid) begin got = 1'b1; word = bus.op_data_from_mem; end
        if (bus.op_inst_valid) wrong = 1'b1;
      end
    end
    check({tag, "_latency"}, 64'(got ? k : 0), 64'(exp_lat));
    check({tag, "_word"}, 64'(word), 64'(exp_word));
    check({tag, "_other_valid"}, 64'(wrong), 64'h0);
    check({tag, "_req_cycles"}, 64'(req_cycles), 64'(exp_req));
    if (exp_req > 0) begin
      check({tag, "_addr"}, 64'(f_addr), 64'(addr));
      check({tag, "_wr"}, 64'(f_wr), 64'(kind == 2));
      check({tag, "_mask"}, 64'(f_mask), 64'((kind == 2) ? mask : 4'hF));
      check({tag, "_stable"}, 64'(f_unstable), 64'h0);
      if (kind == 2) check({tag, "_wdata"}, 64'(f_wdata), 64'(wdata));
    end
    check({tag, "_halted"}, 64'(bus.op_halted), 64'(m_halted));
    check({tag, "_bus_error"}, 64'(bus.op_bus_error), 64'(m_err));
    clear_reqs();
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 64'({bus.op_inst_valid, bus.op_data_valid}), 64'h0);
  endtask

  initial begin
    int          vq[$];
    int          kq[$];
    int          k;
    int          nval;
    logic [5:0]  idx;
    logic [31:0] w;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == EBRK) w = w ^ 32'h1;
      mem[i]     = w;
      ref_mem[i] = w;
    end
    mem[4]     = 32'h0050_0093;
    ref_mem[4] = 32'h0050_0093;
    m_halted   = 1'b0;
    m_err      = 1'b0;
    ack_delay  = 0;
    req_cnt    = 0;
    req_cycles = 0;
    f_unstable = 1'b0;
    clear_reqs();
    bus.ip_inst_addr      = 32'h0;
    bus.ip_data_addr      = 32'h0;
    bus.ip_data_mask      = 4'h0;
    bus.ip_data_from_proc = 32'h0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single zero-wait fetch
    do_txn(0, 32'h10, 4'hF, 32'h0, 0, "fetch");

    // Contention: both held high for four transactions
    addr_q.delete();
    ack_delay        = int'($urandom_range(0, 2));
    bus.ip_inst_req  = 1'b1;
    bus.ip_inst_addr = 32'h40;
    bus.ip_data_rd   = 1'b1;
    bus.ip_data_addr = 32'h80;
    k = 0;
    while (vq.size() < 4 && k < 60) begin
      @(negedge clk);
      k++;
      nval = int'(bus.op_inst_valid) + int'(bus.op_data_valid);
      if (nval > 1) vq.push_back(9);
      else if (bus.op_data_valid) begin
        vq.push_back(1);
        kq.push_back(k);
        check("cont_dword", 64'(bus.op_data_from_mem), 64'(ref_mem[32]));
      end else if (bus.op_inst_valid) begin
        vq.push_back(0);
        kq.push_back(k);
        check("cont_iword", 64'(bus.op_inst_from_mem), 64'(ref_mem[16]));
      end
    end
    clear_reqs();
    @(negedge clk);
    check("cont_count", 64'(vq.size()), 64'd4);
    check("cont_order", 64'({vq[0][3:0], vq[1][3:0], vq[2][3:0], vq[3][3:0]}), 64'h1010);
    check("cont_mem_order", 64'({addr_q[0][7:0], addr_q[1][7:0], addr_q[2][7:0], addr_q[3][7:0]}),
          64'h80408040);
    for (int i = 1; i < 4; i++)
      check("cont_throughput", 64'(kq[i] - kq[i-1]), 64'(ack_delay + 3));

    // Store with delayed ack
    do_txn(2, 32'h20, 4'b0011, 32'hDEAD_BEEF, 3, "store");
    do_txn(1, 32'h20, 4'hF, 32'h0, 0, "store_readback");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      idx = 6'($urandom_range(0, 63));
      if (idx == 6'd12) idx = 6'd13;
      do_txn(int'($urandom_range(0, 2)), {24'h0, idx, 2'b00}, 4'($urandom_range(0, 15)),
             $urandom, int'($urandom_range(0, 4)), "rand");
    end

    // Timeout on a load
    do_txn(1, 32'h60, 4'hF, 32'h0, -1, "timeout");
    do_txn(1, 32'h64, 4'hF, 32'h0, 1, "after_timeout");

    // Halt
    mem[12]     = EBRK;
    ref_mem[12] = EBRK;
    do_txn(0, 32'h30, 4'hF, 32'h0, 1, "halt_fetch");
    for (int i = 0; i < 3; i++) begin
      idx = 6'($urandom_range(0, 63));
      do_txn(0, {24'h0, idx, 2'b00}, 4'hF, 32'h0, 0, "halted_fetch");
    end
    do_txn(1, 32'h50, 4'hF, 32'h0, 2, "load_after_halt");

    // Reset during a pending data transaction
    ack_delay        = -1;
    bus.ip_data_rd   = 1'b1;
    bus.ip_data_addr = 32'h44;
    repeat (3) @(negedge clk);
    check("midreset_req_before", 64'(bus.op_mem_req), 64'h1);
    #2 reset = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    clear_reqs();
    reset    = 1'b1;
    m_halted = 1'b0;
    m_err    = 1'b0;
    nval     = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.op_data_valid || bus.op_inst_valid || bus.op_mem_req) nval++;
    end
    check("midreset_no_pulse", 64'(nval), 64'h0);
    do_txn(0, 32'h10, 4'hF, 32'h0, 0, "fetch_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the processor's instruction-fetch port and data port, which use the same port naming as the processor. It is a request/acknowledge controller. It arbitrates round-robin on simultaneous requests and sequences each transaction with a timeout. It latches an `ebreak` halt so that no further fetches reach memory after end of simulation.

## Interface
- `ADDR_WIDTH`, 32, width of all address buses.
- `TIMEOUT_CYCLES`, 16, maximum cycles to wait for `ip_mem_ack` before aborting; must be ≥2.
- `EBREAK_INST`, 32'h0010_0073, instruction word that triggers halt.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ip_inst_req` in 1: fetch request; held until `op_inst_valid`.
- `ip_inst_addr` in ADDR_WIDTH: fetch address.
- `op_inst_valid` out 1: one-cycle pulse; fetch complete.
- `op_inst_from_mem` out 32: fetched word; holds its value between pulses.
- `ip_data_rd` in 1: load request; held until `op_data_valid`.
- `ip_data_wr` in 1: store request; held until `op_data_valid`.
- `ip_data_addr` in ADDR_WIDTH: data address.
- `ip_data_mask` in 4: byte enables for a store.
- `ip_data_from_proc` in 32: store data.
- `op_data_valid` out 1: one-cycle pulse; load or store complete.
- `op_data_from_mem` out 32: load data; 0 after a store or an aborted transaction.
- `op_mem_req` out 1: memory request; held until ack or timeout.
- `op_mem_addr` out ADDR_WIDTH: memory address.
- `op_mem_wr` out 1: 1 for a store, 0 for a read.
- `op_mem_mask` out 4: byte enables; 4'hF for reads.
- `op_mem_wdata` out 32: memory write data.
- `ip_mem_ack` in 1: memory completed the current request; `ip_mem_rdata` valid in the same cycle.
- `ip_mem_rdata` in 32: memory read data.
- `op_halted` out 1: sticky; `EBREAK_INST` has been fetched.
- `op_bus_error` out 1: sticky; at least one transaction timed out.

## Operation
- FSM states: IDLE, INST, DATA, RESP.
- IDLE samples the requests. A data request is `ip_data_rd | ip_data_wr`; `ip_data_wr` wins if both are high.
  - Only one requester active: grant it.
  - Both active: grant the requester opposite to `last_grant`.
  - `last_grant` resets to inst, so the first contention goes to data.
- On a grant, IDLE registers the address, write flag, mask and wdata, clears the timeout counter, updates `last_grant`, and moves to INST or DATA.
- INST and DATA drive `op_mem_req`=1 with the registered fields. These fields are stable for the whole request.
- In INST/DATA with `ip_mem_ack`=1:
  - For a read, capture `ip_mem_rdata`.
  - For a store, capture 0.
  - Go to RESP.
- In INST/DATA with no ack: increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 without ack, capture 0, set `op_bus_error`, and go to RESP.
- RESP pulses the matching `*_valid` for exactly one cycle, drives the captured word, then returns to IDLE.
- Halt:
  - Set `op_halted` when a completed fetch returns `EBREAK_INST`.
  - While halted, a granted fetch does not go to INST. It goes straight to RESP with word `EBREAK_INST`, and `op_mem_req` stays 0.
  - Data transactions continue normally.
  - Only `reset` clears the halt.
- A request dropped mid-transaction does not abort the transaction. It completes and its valid still pulses.
- An ack in IDLE or RESP is ignored.
- Reset (asynchronous, any state):
  - Return to IDLE.
  - All outputs go to 0: `op_mem_req`, both valids, `op_inst_from_mem`, `op_data_from_mem`, `op_mem_*`, `op_halted`, `op_bus_error`.
  - `last_grant` becomes inst and the counter becomes 0.
  - Any in-flight request is dropped with no valid pulse.

## Timing
- Request first seen high in IDLE at cycle N.
- `op_mem_req` is high from N+1.
- Ack at cycle M ≥ N+1. Valid pulses at M+1. IDLE is reached at M+2, where the next request can be granted.
- Minimum latency from request to valid is 2 cycles with a zero-wait ack at N+1.
- Back-to-back throughput is one transaction per 3 cycles.
- A halted fetch has valid at N+2.
- On timeout, `op_mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles. Valid pulses in the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single fetch: fetch at 0x10, ack at N+1 with rdata 0x00500093. Expect `op_inst_valid` at N+2 with word 0x00500093 and `op_mem_wr`=0, mask 4'hF.
- Contention: inst and data-read held high together for 4 transactions. Expect grant order data, inst, data, inst, with no overlapping `op_mem_req`.
- Store: wr to 0x20, mask 4'b0011, data 0xDEADBEEF, ack delayed 3 cycles. Expect the fields held steady for 4 cycles, then `op_data_valid` with data 0.
- Halt: a fetch returns 0x00100073. Expect `op_halted`=1, and later fetches return 0x00100073 at N+2 with `op_mem_req` never asserted for them. A following load still reaches memory.
- Timeout: load with no ack and `TIMEOUT_CYCLES`=16. Expect `op_mem_req` high for 16 cycles, then a valid pulse with data 0 and `op_bus_error` sticky at 1.
- Reset mid-operation: assert `reset` low during DATA with the ack pending. Expect all outputs 0 immediately. After release, a new fetch completes normally and the earlier load produces no valid pulse.
